set_bit_scanner: RTL and testbench

- Sequential counterpart to the OR-reduction block. The OR-reduction collapses an N-bit vector to a single "any bit set" flag; this block expands a vector back into the ordered list of its set-bit positions.
- Accepts one N-bit vector per load handshake and emits the index of each set bit, lowest first, one per accepted output handshake.
- Used wherever a flag vector (winner/active masks) must be walked serially by downstream control.

---
 rtl/set_bit_scanner_pkg.sv | 16 +
 rtl/set_bit_scanner_lowest_set_finder.sv | 28 ++
 rtl/set_bit_scanner.sv | 89 ++++++++
 tb/tb_set_bit_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/set_bit_scanner_pkg.sv
// Shared definitions for the set-bit scanner: FSM state encoding and the
// index-width helper used to size set-bit positions.
package set_bit_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Never returns 0, so a position field always has at least one bit.
    function automatic int index_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/set_bit_scanner_lowest_set_finder.sv
// Combinational priority finder: the lowest set bit of a vector as an index
// and as a one-hot mask, plus a flag for "exactly one bit set".
module lowest_set_finder
    import set_bit_scanner_pkg::*;
#(
    parameter int N  = 32,
    parameter int IW = index_width(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] low_idx,
    output logic [N-1:0]  low_mask,
    output logic          single
);

    // Scanning downwards lets the lowest set bit win the last assignment.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                low_idx = IW'(i);
            end
        end
    end

    assign low_mask = vec & (~vec + N'(1));
    assign single   = (vec != '0) && ((vec & ~low_mask) == '0);

endmodule

// File: rtl/set_bit_scanner.sv
// Accepts one N-bit vector per load handshake and emits the positions of its
// set bits, lowest first, one per output handshake.
module set_bit_scanner
    import set_bit_scanner_pkg::*;
#(
    parameter  int N  = 32,
    localparam int IW = index_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [N-1:0]  load_vec,
    output logic          idx_valid,
    input  logic          idx_ready,
    output logic [IW-1:0] idx,
    output logic          idx_last,
    output logic          any,
    output logic          done,
    output logic          busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. valid never waits on ready, and while valid is high
    // without ready the offered data (idx, idx_last) stays unchanged.

    state_t        state;
    logic [N-1:0]  shadow;
    logic [IW-1:0] low_idx;
    logic [N-1:0]  low_mask;
    logic          single;

    lowest_set_finder #(
        .N  (N),
        .IW (IW)
    ) u_finder (
        .vec      (shadow),
        .low_idx  (low_idx),
        .low_mask (low_mask),
        .single   (single)
    );

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign idx_valid  = (state == SCAN);
    assign idx        = idx_valid ? low_idx : '0;
    assign idx_last   = idx_valid && single;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            any    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shadow <= load_vec;
                        any    <= |load_vec;
                        if (load_vec != '0) begin
                            state <= SCAN;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (idx_ready) begin
                        shadow <= shadow & ~low_mask;
                        if (single) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Directed bench for set_bit_scanner: a reference queue of {last, index}
// entries is filled on each accepted load and drained on each idx handshake.
module tb_set_bit_scanner;

    localparam int N  = 32;
    localparam int IW = 5;
    localparam int W  = IW + 1;

    logic          clk;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [N-1:0]  load_vec;
    logic          idx_valid;
    logic          idx_ready;
    logic [IW-1:0] idx;
    logic          idx_last;
    logic          any;
    logic          done;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    logic [W-1:0] exp_q[$];

    set_bit_scanner #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_vec   (load_vec),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx        (idx),
        .idx_last   (idx_last),
        .any        (any),
        .done       (done),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: every set bit, lowest first; last when no higher bit set.
    task automatic push_expected(input logic [N-1:0] v);
        logic [N-1:0] higher;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                higher = v >> (i + 1);
                exp_q.push_back({(higher == '0), IW'(i)});
            end
        end
    endtask

    task automatic load(input logic [N-1:0] v);
        int n = 0;
        while (load_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("load_ready_wait", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_vec   = v;
        push_expected(v);
        tick();
        load_valid = 1'b0;
        load_vec   = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            if (idx_valid === 1'b1) valid_cnt++;
            if (idx_valid === 1'b1 && idx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_idx", {27'd0, idx}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_idx", {27'd0, idx}, {27'd0, e[IW-1:0]});
                    check("sb_idx_last", {31'd0, idx_last}, {31'd0, e[IW]});
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        int v0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_vec   = '0;
        idx_ready  = 1'b0;
        tick();
        tick();
        check("rst_idx_valid", {31'd0, idx_valid}, 32'd0);
        check("rst_idx", {27'd0, idx}, 32'd0);
        check("rst_idx_last", {31'd0, idx_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd1);
        check("rst_any", {31'd0, any}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Zero vector: straight to the done pulse, never a valid index.
        v0 = valid_cnt;
        load(32'h0000_0000);
        check("zero_done_t1", {31'd0, done}, 32'd1);
        check("zero_any", {31'd0, any}, 32'd0);
        check("zero_busy_t1", {31'd0, busy}, 32'd1);
        check("zero_load_ready_t1", {31'd0, load_ready}, 32'd0);
        tick();
        check("zero_done_t2", {31'd0, done}, 32'd0);
        check("zero_load_ready_t2", {31'd0, load_ready}, 32'd1);
        check("zero_no_valid", valid_cnt - v0, 32'd0);

        // Sparse vector with ready held high.
        idx_ready = 1'b1;
        load(32'h8000_0001);
        check("sparse_valid", {31'd0, idx_valid}, 32'd1);
        check("sparse_idx0", {27'd0, idx}, 32'd0);
        check("sparse_last0", {31'd0, idx_last}, 32'd0);
        tick();
        check("sparse_idx31", {27'd0, idx}, 32'd31);
        check("sparse_last31", {31'd0, idx_last}, 32'd1);
        tick();
        check("sparse_done", {31'd0, done}, 32'd1);
        check("sparse_any", {31'd0, any}, 32'd1);
        tick();
        check("sparse_load_ready", {31'd0, load_ready}, 32'd1);

        // Backpressure: index must hold while the consumer stalls.
        idx_ready = 1'b0;
        load(32'h0000_00A0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", {31'd0, idx_valid}, 32'd1);
            check("bp_hold_idx", {27'd0, idx}, 32'd5);
            check("bp_hold_last", {31'd0, idx_last}, 32'd0);
            if (i < 2) tick();
        end
        idx_ready = 1'b1;
        tick();
        check("bp_idx7", {27'd0, idx}, 32'd7);
        check("bp_last7", {31'd0, idx_last}, 32'd1);
        tick();
        check("bp_done", {31'd0, done}, 32'd1);
        tick();

        // Load attempt during a scan must be ignored.
        load(32'h0000_000F);
        load_valid = 1'b1;
        load_vec   = 32'hFFFF_FFFF;
        check("busy_load_ready", {31'd0, load_ready}, 32'd0);
        tick();
        load_valid = 1'b0;
        load_vec   = '0;
        wait_done();
        tick();
        check("busy_q_empty", exp_q.size(), 32'd0);

        // Full vector: 32 consecutive indices, one done pulse.
        d0 = done_cnt;
        load(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            check("full_idx", {27'd0, idx}, i);
            check("full_last", {31'd0, idx_last}, (i == 31) ? 32'd1 : 32'd0);
            tick();
        end
        check("full_done", {31'd0, done}, 32'd1);
        tick();
        check("full_done_pulses", done_cnt - d0, 32'd1);

        // Reset in the middle of a scan discards the vector.
        d0 = done_cnt;
        load(32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) tick();
        check("mid_idx4", {27'd0, idx}, 32'd4);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("mid_rst_valid", {31'd0, idx_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_any", {31'd0, any}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("mid_rel_load_ready", {31'd0, load_ready}, 32'd1);
        check("mid_no_done", done_cnt - d0, 32'd0);
        load(32'h0000_0004);
        check("post_idx2", {27'd0, idx}, 32'd2);
        check("post_last", {31'd0, idx_last}, 32'd1);
        wait_done();
        tick();
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
